// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one-outstanding-request memory front end feeding a
// 2-entry {PC, instruction} queue, with redirect handling for branches/PC writes.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        InstrValid,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      state;
    entry_t      head, tail;
    logic [1:0]  count;
    logic [31:0] fpc;
    logic [31:0] stale_addr;

    logic   fire, push, pop;
    entry_t new_entry;

    // DROP keeps presenting the abandoned address so the memory sees a stable request until ack.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fpc;
        if (!reset) begin
            case (state)
                IDLE:    imem_req = (count < 2'd2);
                WAIT:    imem_req = 1'b1;
                DROP: begin
                    imem_req  = 1'b1;
                    imem_addr = stale_addr;
                end
                default: imem_req = 1'b0;
            endcase
        end
    end

    assign fire      = imem_req & imem_ack;
    assign push      = fire & ~Redirect & (state != DROP);
    assign pop       = (count != 2'd0) & ~Stall & ~Redirect;
    assign new_entry = '{pc: fpc, instr: imem_rdata};

    assign InstrValid = (count != 2'd0);
    assign InstrD     = InstrValid ? head.instr : 32'h0;
    assign PCD        = InstrValid ? head.pc    : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            count      <= 2'd0;
            stale_addr <= 32'h0;
            head       <= '0;
            tail       <= '0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (fire) begin
                        state <= IDLE;
                    end else if (imem_req) begin
                        if (Redirect) begin
                            state      <= DROP;
                            stale_addr <= imem_addr;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                DROP:    if (imem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (Redirect)
                fpc <= {RedirectPC[31:2], 2'b00};
            else if (push)
                fpc <= fpc + 32'd4;

            // Requests are only issued with count < 2, so push never meets a full queue.
            if (Redirect) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) head <= new_entry;
                        else               tail <= new_entry;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head  <= tail;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            head <= new_entry;
                        end else begin
                            head <= tail;
                            tail <= new_entry;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns ~addr after a programmable ack latency.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        InstrValid;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;

    int lat      = 0;
    int wait_cnt = 0;
    int npass    = 0;
    int ntot     = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrValid(InstrValid), .InstrD(InstrD), .PCD(PCD),
        .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC)
    );

    always #5 clk = ~clk;

    // memory model: ack after 'lat' waiting cycles, data = ~addr
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = ~imem_addr;

    always @(posedge clk or posedge reset) begin
        if (reset)                      wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else                            wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!InstrValid && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'b0, InstrValid}, 32'h1);
    endtask

    initial begin
        reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
        step(); step();
        chk("rst_req",   {31'b0, imem_req},   32'h0);
        chk("rst_valid", {31'b0, InstrValid}, 32'h0);
        chk("rst_instr", InstrD, 32'h0);
        chk("rst_pcd",   PCD,    32'h0);

        // zero-wait streaming
        reset = 1'b0;
        #1;
        chk("first_addr", imem_addr, 32'h0);
        chk("first_req",  {31'b0, imem_req}, 32'h1);
        step();
        chk("s0_pcd",   PCD,    32'h0000_0000);
        chk("s0_instr", InstrD, 32'hFFFF_FFFF);
        step();
        chk("s1_pcd",   PCD,    32'h0000_0004);
        chk("s1_instr", InstrD, 32'hFFFF_FFFB);
        step();
        chk("s2_pcd",   PCD,    32'h0000_0008);
        chk("s2_instr", InstrD, 32'hFFFF_FFF7);
        step();
        chk("s3_pcd",   PCD,    32'h0000_000C);
        chk("s3_instr", InstrD, 32'hFFFF_FFF3);

        // stall: queue fills with 12,16 and requests stop
        Stall = 1'b1;
        repeat (5) step();
        chk("stall_req",  {31'b0, imem_req}, 32'h0);
        chk("stall_head", PCD, 32'h0000_000C);
        chk("stall_vld",  {31'b0, InstrValid}, 32'h1);
        Stall = 1'b0;
        step();
        chk("rel_pcd0", PCD, 32'h0000_0010);
        step();
        chk("rel_pcd1", PCD, 32'h0000_0014);
        step();
        chk("rel_pcd2",   PCD,    32'h0000_0018);
        chk("rel_instr2", InstrD, 32'hFFFF_FFE7);

        // redirect while waiting on a slow memory
        lat = 2;
        #1;
        step();
        chk("wait_addr", imem_addr, 32'h0000_001C);
        chk("wait_vld",  {31'b0, InstrValid}, 32'h0);
        Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        step();
        Redirect = 1'b0;
        chk("drop_addr", imem_addr, 32'h0000_001C);
        chk("drop_req",  {31'b0, imem_req}, 32'h1);
        step();
        chk("drop_nopush", {31'b0, InstrValid}, 32'h0);
        chk("redir_addr",  imem_addr, 32'h0000_0100);
        wait_valid("redir_timeout");
        chk("redir_pcd",   PCD,    32'h0000_0100);
        chk("redir_instr", InstrD, 32'hFFFF_FEFF);

        // redirect with a full queue
        lat = 0; Stall = 1'b1;
        #1;
        step();
        chk("full_req", {31'b0, imem_req}, 32'h0);
        Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        step();
        Redirect = 1'b0;
        chk("full_flush", {31'b0, InstrValid}, 32'h0);
        chk("full_addr",  imem_addr, 32'h0000_0200);
        step();
        chk("full_pcd", PCD, 32'h0000_0200);

        // redirect coincident with an ack: rdata dropped, misaligned target forced aligned
        chk("ack_coinc", {31'b0, imem_ack}, 32'h1);
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFE;
        step();
        Redirect = 1'b0; Stall = 1'b0;
        chk("coinc_empty", {31'b0, InstrValid}, 32'h0);
        chk("align_addr",  imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pcd",   PCD,    32'hFFFF_FFFC);
        chk("wrap_instr", InstrD, 32'h0000_0003);
        chk("wrap_addr",  imem_addr, 32'h0000_0000);
        step();
        chk("wrap_pcd1", PCD, 32'h0000_0000);

        // reset pulse during WAIT
        lat = 3;
        #1;
        step();
        chk("w2_addr", imem_addr, 32'h0000_0004);
        reset = 1'b1;
        #1;
        chk("mid_rst_req",   {31'b0, imem_req},   32'h0);
        chk("mid_rst_valid", {31'b0, InstrValid}, 32'h0);
        chk("mid_rst_instr", InstrD, 32'h0);
        chk("mid_rst_pcd",   PCD,    32'h0);
        chk("mid_rst_addr",  imem_addr, 32'h0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req",  {31'b0, imem_req}, 32'h1);
        wait_valid("post_rst_timeout");
        chk("post_rst_pcd",   PCD,    32'h0);
        chk("post_rst_instr", InstrD, 32'hFFFF_FFFF);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
